// File: rtl/mux3_arb_pkg.sv
// Shared types and constants for the three-way round-robin mux arbiter.
package mux3_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = '0;
        case (idx)
            SEL_D0:  oh = 3'b001;
            SEL_D1:  oh = 3'b010;
            SEL_D2:  oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick over three requesters; search starts after
// `last` and wraps, so `last` itself is considered lowest priority.
module rr_pick3
    import mux3_arb_pkg::*;
(
    input  logic [2:0] req_masked,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] ord0, ord1, ord2;

    always_comb begin
        ord0 = SEL_D0;
        ord1 = SEL_D1;
        ord2 = SEL_D2;
        case (last)
            SEL_D0: begin ord0 = SEL_D1; ord1 = SEL_D2; ord2 = SEL_D0; end
            SEL_D1: begin ord0 = SEL_D2; ord1 = SEL_D0; ord2 = SEL_D1; end
            default: begin ord0 = SEL_D0; ord1 = SEL_D1; ord2 = SEL_D2; end
        endcase

        valid  = |req_masked;
        winner = SEL_D0;
        if (req_masked[ord0])      winner = ord0;
        else if (req_masked[ord1]) winner = ord1;
        else if (req_masked[ord2]) winner = ord2;
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter owning the select of a 3:1 data mux, with a hold limit.
// release_i is the holder's release strobe (release is a reserved word).
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       release_i,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    localparam int unsigned    CW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0] pick_mask;
    logic [1:0] pick_last;
    logic       pick_valid;
    logic [1:0] pick_winner;
    logic       rel_evt;
    logic       force_rot;

    // One picker serves both cases: in GRANTED the holder is masked and the
    // search starts after it, since it becomes `last` on the handover.
    always_comb begin
        if (state_q == GRANTED) begin
            pick_mask = req & ~idx_to_onehot(sel_q);
            pick_last = sel_q;
        end else begin
            pick_mask = req;
            pick_last = last_q;
        end
    end

    rr_pick3 u_pick (
        .req_masked (pick_mask),
        .last       (pick_last),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rel_evt   = release_i || !req[sel_q];
        force_rot = (cnt_q == CNT_MAX) && pick_valid;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANTED;
                    grant_d = idx_to_onehot(pick_winner);
                    sel_d   = pick_winner;
                    cnt_d   = '0;
                end
            end
            GRANTED: begin
                if (rel_evt || force_rot) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (pick_valid) begin
                        grant_d = idx_to_onehot(pick_winner);
                        sel_d   = pick_winner;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_D0;
            last_q  <= SEL_D2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a behavioural arbitration model.
module tb_mux3_rr_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       release_i;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Model state: holder index (-1 = idle), previous holder, hold count, select.
    int m_holder;
    int m_last;
    int m_cnt;
    int m_sel;

    mux3_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [2:0] cand, input int base);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (base + k) % 3;
            if (cand[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot_of(input int h);
        if (h < 0 || h > 2) return 3'b000;
        return 3'(1 << h);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int         w;
        logic [2:0] others;
        if (!rst_n) begin
            m_holder <= -1;
            m_last   <= 2;
            m_cnt    <= 0;
            m_sel    <= 0;
        end else if (m_holder < 0) begin
            if (req != 3'b000) begin
                w = pick(req, m_last);
                m_holder <= w;
                m_sel    <= w;
                m_cnt    <= 0;
            end
        end else begin
            others = req & ~onehot_of(m_holder);
            if (release_i || !req[m_holder] || (m_cnt == MH - 1 && others != 3'b000)) begin
                m_last <= m_holder;
                m_cnt  <= 0;
                if (others != 3'b000) begin
                    w = pick(others, m_holder);
                    m_holder <= w;
                    m_sel    <= w;
                end else begin
                    m_holder <= -1;
                end
            end else if (m_cnt < MH - 1) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_grant", int'(grant), int'(onehot_of(m_holder)));
            chk("model_sel", int'(sel), m_sel);
            chk("model_busy", int'(busy), int'(m_holder >= 0));
            chk("grant_onehot0", int'($onehot0(grant)), 1);
            chk("sel_legal", int'(sel != 2'b11), 1);
            if (busy) chk("sel_matches_grant", int'(grant), int'(onehot_of(int'(sel))));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [2:0] g, input logic [1:0] s);
        chk({name, "_grant"}, int'(grant), int'(g));
        chk({name, "_sel"}, int'(sel), int'(s));
        chk({name, "_busy"}, int'(busy), int'(|g));
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 3'b000;
        release_i = 1'b0;
        #12;
        expect_out("reset", 3'b000, 2'b00);
        rst_n = 1'b1;

        // All three requesting with release each cycle: strict rotation 0,1,2.
        req = 3'b111; release_i = 1'b1;
        cyc(); expect_out("rot0", 3'b001, 2'b00);
        cyc(); expect_out("rot1", 3'b010, 2'b01);
        cyc(); expect_out("rot2", 3'b100, 2'b10);

        // Holder 2 drops its request with nobody else waiting: idle, sel kept.
        req = 3'b000; release_i = 1'b0;
        cyc(); expect_out("drop_idle", 3'b000, 2'b10);
        cyc(); expect_out("idle_stay", 3'b000, 2'b10);

        // Fresh request after holder 2: search restarts at requester 0.
        req = 3'b001;
        cyc(); expect_out("restart0", 3'b001, 2'b00);
        // Contention from the first granted cycle: exactly MH granted cycles.
        req = 3'b011;
        for (int i = 2; i <= MH; i++) begin
            cyc(); expect_out("hold0", 3'b001, 2'b00);
        end
        cyc(); expect_out("timeout_to1", 3'b010, 2'b01);

        // Sole requester keeps the grant indefinitely; counter saturates.
        req = 3'b010;
        for (int i = 0; i < 20; i++) begin
            cyc(); expect_out("solo1", 3'b010, 2'b01);
        end
        // Saturated counter means rotation on the very next edge.
        req = 3'b011;
        cyc(); expect_out("sat_rotate", 3'b001, 2'b00);

        // Release coinciding with the timeout is a single handover.
        req = 3'b111;
        for (int i = 2; i <= MH; i++) begin
            cyc(); expect_out("hold0b", 3'b001, 2'b00);
        end
        release_i = 1'b1;
        cyc(); expect_out("rel_and_timeout", 3'b010, 2'b01);
        release_i = 1'b0;
        cyc(); expect_out("no_double", 3'b010, 2'b01);

        // Reset mid-grant while holding requester 2: clears without a clock edge.
        release_i = 1'b1;
        cyc(); expect_out("to2", 3'b100, 2'b10);
        release_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 expect_out("async_reset", 3'b000, 2'b00);
        rst_n = 1'b1;
        cyc(); expect_out("post_reset", 3'b001, 2'b00);

        // Random traffic checked every cycle by the model and invariants.
        for (int i = 0; i < 10000; i++) begin
            req       = 3'($urandom_range(0, 7));
            release_i = ($urandom_range(0, 3) == 0);
            cyc();
        end

        req = 3'b000; release_i = 1'b0;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
